// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared helpers for the single-clock FIFO: ceil-log2,
//                read-mode selector constants and pointer-width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int READ_MODE_STD  = 0;
  localparam int READ_MODE_FWFT = 1;

  // Ceiling log2; clogb2(16) = 4, clogb2(1024) = 10.
  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Pointers carry one extra MSB so a wrapped write pointer differs from the
  // read pointer when the RAM is full.
  function automatic int ptr_width(input int depth);
    return clogb2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_dual_mode_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_dual_mode_if
//  Description : Write/read handshake and status bundle of the dual-mode FIFO.
//                master = producer/consumer side, slave = FIFO side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_dual_mode_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024
) ();

  logic                        wr_en;
  logic [DATA_WIDTH-1:0]       din;
  logic                        full;
  logic                        prog_full;
  logic                        overflow;
  logic                        rd_en;
  logic [DATA_WIDTH-1:0]       dout;
  logic                        valid;
  logic                        empty;
  logic                        prog_empty;
  logic                        underflow;
  logic [ptr_width(DEPTH)-1:0] data_count;

  modport master (
    output wr_en, din, rd_en,
    input  full, prog_full, overflow, dout, valid, empty, prog_empty,
           underflow, data_count
  );

  modport slave (
    input  wr_en, din, rd_en,
    output full, prog_full, overflow, dout, valid, empty, prog_empty,
           underflow, data_count
  );

endinterface
`default_nettype wire

// File: rtl/sync_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sync_sdp_ram
//  Description : Simple dual-port RAM, one write port and one synchronous
//                read port with read enable. The read register is the only
//                reset element so the array itself maps onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_sdp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  localparam int AW        = clogb2(DEPTH)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  we_i,
  input  wire logic [AW-1:0]         waddr_i,
  input  wire logic [DATA_WIDTH-1:0] wdata_i,
  input  wire logic                  re_i,
  input  wire logic [AW-1:0]         raddr_i,
  output logic      [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port: no reset on the array.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_dual_mode.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_dual_mode
//  Description : Single-clock FIFO with standard (registered read) or
//                first-word-fall-through presentation, occupancy count,
//                programmable thresholds and overflow/underflow pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_dual_mode
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int DEPTH             = 1024,
  parameter int READ_MODE         = READ_MODE_FWFT,
  parameter int PROG_FULL_THRESH  = DEPTH - 4,
  parameter int PROG_EMPTY_THRESH = 4
) (
  input wire logic             clk,
  input wire logic             global_rst_n,
  sync_fifo_dual_mode_if.slave fifo
);

  localparam int AW = clogb2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  // Elaboration-time parameter guards.
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 16 || DEPTH > 4096) begin : g_bad_depth
    $error("sync_fifo_dual_mode: DEPTH must be a power of two in 16..4096");
  end
  if (PROG_FULL_THRESH < 0 || PROG_FULL_THRESH > DEPTH) begin : g_bad_pfull
    $error("sync_fifo_dual_mode: PROG_FULL_THRESH outside 0..DEPTH");
  end
  if (PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH > DEPTH) begin : g_bad_pempty
    $error("sync_fifo_dual_mode: PROG_EMPTY_THRESH outside 0..DEPTH");
  end
  if (READ_MODE != READ_MODE_STD && READ_MODE != READ_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_dual_mode: READ_MODE must be 0 or 1");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;   // next RAM word to fetch
  logic [PW-1:0] count_q,  count_d;    // words held, incl. FWFT output reg
  logic          valid_q,  valid_d;
  logic          overflow_q, underflow_q;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_pop;
  logic          w_ram_re;
  logic [PW-1:0] w_ram_cnt;            // written but not yet fetched

  // Flags, accept decisions, prefetch control and next state.
  always_comb begin
    w_full    = (count_q == PW'(DEPTH));
    w_ram_cnt = wr_ptr_q - rd_ptr_q;
    w_empty   = 1'b1;
    w_pop     = 1'b0;
    w_ram_re  = 1'b0;
    valid_d   = 1'b0;
    if (READ_MODE == READ_MODE_FWFT) begin
      // Output register is the head; refill it whenever it is free or being
      // popped and the RAM still has an unfetched word.
      w_empty  = ~valid_q;
      w_pop    = fifo.rd_en & valid_q;
      w_ram_re = (~valid_q | fifo.rd_en) & (w_ram_cnt != '0);
      valid_d  = w_ram_re | (valid_q & ~w_pop);
    end else begin
      w_empty  = (count_q == '0);
      w_pop    = fifo.rd_en & ~w_empty;
      w_ram_re = w_pop;
      valid_d  = w_pop;
    end
    w_wr_acc = fifo.wr_en & ~w_full;
    wr_ptr_d = wr_ptr_q + PW'(w_wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(w_ram_re);
    count_d  = count_q + PW'(w_wr_acc) - PW'(w_pop);
  end

  // State registers; async assert discards all contents at once.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      overflow_q  <= fifo.wr_en & w_full;
      underflow_q <= fifo.rd_en & w_empty;
    end
  end

  sync_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (global_rst_n),
    .we_i    (w_wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (fifo.din),
    .re_i    (w_ram_re),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (fifo.dout)
  );

  assign fifo.full       = w_full;
  assign fifo.empty      = w_empty;
  assign fifo.prog_full  = (count_q >= PW'(PROG_FULL_THRESH));
  assign fifo.prog_empty = (count_q <= PW'(PROG_EMPTY_THRESH));
  assign fifo.valid      = valid_q;
  assign fifo.overflow   = overflow_q;
  assign fifo.underflow  = underflow_q;
  assign fifo.data_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_dual_mode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_dual_mode
//  Description : Drives an FWFT and a standard-mode FIFO with identical
//                stimulus and compares both against queue-based models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_dual_mode;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          global_rst_n;
  logic          wr_en, rd_en;
  logic [DW-1:0] din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_dual_mode_if #(.DATA_WIDTH(DW), .DEPTH(DP)) if_f ();
  sync_fifo_dual_mode_if #(.DATA_WIDTH(DW), .DEPTH(DP)) if_s ();

  assign if_f.wr_en = wr_en;
  assign if_f.din   = din;
  assign if_f.rd_en = rd_en;
  assign if_s.wr_en = wr_en;
  assign if_s.din   = din;
  assign if_s.rd_en = rd_en;

  sync_fifo_dual_mode #(
    .DATA_WIDTH(DW), .DEPTH(DP), .READ_MODE(1),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)
  ) dut_fwft (
    .clk(clk), .global_rst_n(global_rst_n), .fifo(if_f)
  );

  sync_fifo_dual_mode #(
    .DATA_WIDTH(DW), .DEPTH(DP), .READ_MODE(0),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)
  ) dut_std (
    .clk(clk), .global_rst_n(global_rst_n), .fifo(if_s)
  );

  // Reference model. FWFT: a word is presented once at least one full edge
  // has passed since the edge that wrote it. Standard: a read returns the
  // head word one edge later.
  int            t = 0;                 // edges completed
  logic [DW-1:0] qf_d[$];
  int            qf_t[$];
  logic [DW-1:0] qs_d[$];
  logic [DW-1:0] exp_f_dout, exp_s_dout;
  logic          exp_s_valid;
  logic          exp_f_ovf, exp_f_unf, exp_s_ovf, exp_s_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qf_d.delete();
    qf_t.delete();
    qs_d.delete();
    exp_f_dout  = '0;
    exp_s_dout  = '0;
    exp_s_valid = 1'b0;
    exp_f_ovf   = 1'b0;
    exp_f_unf   = 1'b0;
    exp_s_ovf   = 1'b0;
    exp_s_unf   = 1'b0;
  endtask

  task automatic check_all();
    logic vis;
    int   nf, ns;
    nf  = qf_d.size();
    ns  = qs_d.size();
    vis = (nf > 0) && (qf_t[0] < t);
    if (vis) exp_f_dout = qf_d[0];
    chk("fwft_valid",      32'(if_f.valid),      32'(vis));
    chk("fwft_empty",      32'(if_f.empty),      32'(!vis));
    chk("fwft_dout",       32'(if_f.dout),       32'(exp_f_dout));
    chk("fwft_count",      32'(if_f.data_count), 32'(nf));
    chk("fwft_full",       32'(if_f.full),       32'(nf == DP));
    chk("fwft_prog_full",  32'(if_f.prog_full),  32'(nf >= 12));
    chk("fwft_prog_empty", 32'(if_f.prog_empty), 32'(nf <= 4));
    chk("fwft_overflow",   32'(if_f.overflow),   32'(exp_f_ovf));
    chk("fwft_underflow",  32'(if_f.underflow),  32'(exp_f_unf));
    chk("std_valid",       32'(if_s.valid),      32'(exp_s_valid));
    chk("std_dout",        32'(if_s.dout),       32'(exp_s_dout));
    chk("std_empty",       32'(if_s.empty),      32'(ns == 0));
    chk("std_count",       32'(if_s.data_count), 32'(ns));
    chk("std_full",        32'(if_s.full),       32'(ns == DP));
    chk("std_prog_full",   32'(if_s.prog_full),  32'(ns >= 12));
    chk("std_prog_empty",  32'(if_s.prog_empty), 32'(ns <= 4));
    chk("std_overflow",    32'(if_s.overflow),   32'(exp_s_ovf));
    chk("std_underflow",   32'(if_s.underflow),  32'(exp_s_unf));
  endtask

  // One clock: drive inputs, decide acceptance from the pre-edge model,
  // apply at the edge, check at the following falling edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    logic f_vis, f_wacc, f_pop, s_wacc, s_racc;
    wr_en = w;
    din   = d;
    rd_en = r;
    f_vis  = (qf_d.size() > 0) && (qf_t[0] < t);
    f_wacc = w && (qf_d.size() < DP);
    f_pop  = r && f_vis;
    s_wacc = w && (qs_d.size() < DP);
    s_racc = r && (qs_d.size() > 0);
    exp_f_ovf = w && (qf_d.size() == DP);
    exp_f_unf = r && !f_vis;
    exp_s_ovf = w && (qs_d.size() == DP);
    exp_s_unf = r && (qs_d.size() == 0);
    @(posedge clk);
    t++;
    if (f_pop) begin
      void'(qf_d.pop_front());
      void'(qf_t.pop_front());
    end
    if (f_wacc) begin
      qf_d.push_back(d);
      qf_t.push_back(t);
    end
    exp_s_valid = s_racc;
    if (s_racc) exp_s_dout = qs_d.pop_front();
    if (s_wacc) qs_d.push_back(d);
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2;
    global_rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    #1;
    model_clear();
    check_all();                       // no clock edge has occurred yet
    @(posedge clk);
    t++;
    @(negedge clk);
    global_rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    global_rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    model_clear();
    #3;
    global_rst_n = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    global_rst_n = 1'b1;
    check_all();

    // 1: single write into empty FIFO, head appears one edge later
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // 2: fill to full, then a rejected write
    for (int i = 0; i < DP; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // 3: drain with rd_en held, then one read too many
    for (int i = 0; i < DP; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // 4: half full, simultaneous write and read for 40 cycles
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

    // 5: write and read together on an empty FIFO
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // random traffic with varying bias towards fill or drain
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      step(($urandom_range(99) < bias), 8'($urandom), ($urandom_range(99) >= bias));
    end
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);

    // 6: asynchronous reset with 10 words stored, then a fresh round trip
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    async_reset();
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_dual_mode.md
Name: sync_fifo_dual_mode

Overview:
- Single-clock FIFO, parametrised width and depth.
- READ_MODE selects standard (registered read) or first-word-fall-through presentation.
- Adds an occupancy count, programmable thresholds, a valid strobe, and sticky-free overflow/underflow pulses.
- Used inside one clock domain wherever a buffer with a look-ahead head word is needed.
- Storage is inferred block RAM with a synchronous read port.

Parameters:
- DATA_WIDTH, 64, width of din/dout.
- DEPTH, 1024, capacity in words; power of two, 16..4096.
- READ_MODE, 1, 0 = standard, 1 = FWFT.
- PROG_FULL_THRESH, DEPTH-4, prog_full asserts when data_count >= value.
- PROG_EMPTY_THRESH, 4, prog_empty asserts when data_count <= value.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- global_rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- full  out  1  no write accepted this cycle.
- prog_full  out  1  threshold flag.
- overflow  out  1  one-cycle pulse: previous cycle's wr_en was rejected.
- rd_en  in  1  read request (FWFT: pop/acknowledge of head word).
- dout  out  DATA_WIDTH  read data.
- valid  out  1  dout holds a freshly read word (standard) / the head word (FWFT).
- empty  out  1  no read accepted this cycle.
- prog_empty  out  1  threshold flag.
- underflow  out  1  one-cycle pulse: previous cycle's rd_en was rejected.
- data_count  out  clogb2(DEPTH)+1  words held, including the FWFT output register.

Behaviour:
- Reset (async assert, sync release):
  - Pointers, count and all flags cleared; dout = 0.
  - empty = 1, prog_empty = 1; full, prog_full, valid, overflow, underflow = 0.
  - Reset mid-operation discards all contents immediately.
- Pointers are clogb2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty on wrap.
- Addresses wrap modulo DEPTH.
- Write: accepted when wr_en & ~full.
  - Word written to RAM[wr_ptr]; wr_ptr increments.
  - wr_en & full: write dropped, no state change, overflow = 1 next cycle.
  - full is evaluated before the same-cycle read, so a write while full is dropped even if rd_en = 1.
- Standard mode (READ_MODE = 0):
  - Read accepted when rd_en & ~empty.
  - dout updates at the next edge (1-cycle latency); valid = 1 for exactly that cycle.
  - dout holds its value otherwise.
  - empty = (data_count == 0).
- FWFT mode (READ_MODE = 1):
  - dout is the RAM read register.
  - Prefetch fires when (~valid | rd_en) and RAM holds an unfetched word; read address = rd_ptr.
  - Write accepted at edge k into an empty FIFO: valid = 1, empty = 0 and dout = that word after edge k+1.
  - rd_en while valid pops the head; the next word appears after the same edge if available, otherwise valid falls.
  - Sustains 1 word/cycle.
  - empty = ~valid.
  - rd_en & ~valid is rejected and gives underflow.
- data_count:
  - +1 on an accepted write, -1 on an accepted pop, unchanged when both occur.
  - Range 0..DEPTH; full = (data_count == DEPTH).
  - In FWFT, a word in the output register is counted until popped.
- Empty FIFO with wr_en & rd_en in the same cycle: write accepted, read rejected (underflow = 1).
- prog_full, prog_empty, full and empty are all decoded from registered state; no combinational path from wr_en/rd_en to any flag.
- Illegal parameters (DEPTH not a power of two, thresholds outside 0..DEPTH) stop elaboration via a generate-time check.

Decomposition:
- Shared package fifo_pkg holds:
  - clogb2 function;
  - READ_MODE_STD = 0 and READ_MODE_FWFT = 1 constants;
  - pointer-width derivation.
- One sub-module, sync_sdp_ram: simple dual-port RAM with one write port and one synchronous read port with read enable, parametrised width and depth.
- The dout register is the RAM read output, so it stays inferable as block RAM.
- Top level holds pointers, count, flags and FWFT prefetch control.

Test Plan (DATA_WIDTH = 8, DEPTH = 16, thresholds 12/4):
1. Reset release, then write 0x11 at edge k in FWFT mode -> empty = 0, valid = 1, dout = 0x11 after edge k+1; data_count = 1.
2. Write 16 words 0x00..0x0F without reading -> full = 1 and data_count = 16 after the 16th edge; prog_full from count 12. A 17th wr_en gives overflow = 1 for one cycle with contents unchanged.
3. Full FIFO, rd_en held 16 cycles -> dout sequence 0x00..0x0F with no bubbles in FWFT mode. In standard mode the same sequence lags rd_en by 1 cycle with valid high each cycle. Ends with empty = 1 and data_count = 0.
4. Continuous wr_en & rd_en for 40 cycles at half-full (8 words) -> data_count stays 8, pointers wrap twice, output order matches the input order.
5. Empty FIFO, wr_en & rd_en together with din = 0xA5 -> underflow = 1 next cycle; data_count = 1; 0xA5 later read correctly.
6. Assert global_rst_n low asynchronously mid-burst with 10 words stored -> all outputs return to reset values without waiting for a clock edge; the next write/read round-trip returns fresh data only.
